// File: rtl/reorder_buffer.sv
// 16-entry reorder buffer: in-order issue at tail, out-of-order completion via the
// result broadcast, in-order commit at head, and a full flush on a mispredicted branch.
module reorder_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        issue_is_br,
    output logic        rob_full,
    output logic        upd,
    output logic [3:0]  upd_idx,
    output logic [4:0]  upd_rd,
    input  logic        cdb_valid,
    input  logic [3:0]  cdb_idx,
    input  logic [31:0] cdb_val,
    input  logic        cdb_mispred,
    input  logic [31:0] cdb_target,
    input  logic [3:0]  q1_idx,
    input  logic [3:0]  q2_idx,
    output logic        q1_ready,
    output logic        q2_ready,
    output logic [31:0] q1_val,
    output logic [31:0] q2_val,
    output logic        write,
    output logic [3:0]  write_idx,
    output logic [4:0]  write_rd,
    output logic [31:0] new_val,
    output logic        jp_wrong,
    output logic [31:0] redirect_pc,
    output logic [3:0]  dbg_head,
    output logic [3:0]  dbg_tail,
    output logic [4:0]  dbg_count
);

    logic [15:0] busy_q, busy_d, ready_q, ready_d;
    logic [15:0] is_br_q, is_br_d, mispred_q, mispred_d;
    logic [4:0]  rd_q [16];
    logic [4:0]  rd_d [16];
    logic [31:0] val_q [16];
    logic [31:0] val_d [16];
    logic [31:0] target_q [16];
    logic [31:0] target_d [16];
    logic [3:0]  head_q, head_d, tail_q, tail_d;
    logic [4:0]  count_q, count_d;

    logic accept, commit, q1_hit, q2_hit;

    // Handshakes are combinational in the cycle they occur; nothing is accepted
    // while rst is high so the flops and the strobes agree during reset.
    assign rob_full = !rst && (count_q == 5'd16);
    assign commit   = !rst && rdy && (count_q != 5'd0) && ready_q[head_q];
    assign jp_wrong = commit && is_br_q[head_q] && mispred_q[head_q];
    assign accept   = !rst && rdy && issue_valid && (count_q != 5'd16) && !jp_wrong;

    assign upd         = accept;
    assign upd_idx     = tail_q;
    assign upd_rd      = issue_rd;
    assign write       = commit;
    assign write_idx   = head_q;
    assign write_rd    = rd_q[head_q];
    assign new_val     = val_q[head_q];
    assign redirect_pc = jp_wrong ? target_q[head_q] : 32'd0;

    // Operand lookup with same-cycle bypass from the broadcast bus.
    assign q1_hit   = cdb_valid && (cdb_idx == q1_idx) && busy_q[q1_idx];
    assign q2_hit   = cdb_valid && (cdb_idx == q2_idx) && busy_q[q2_idx];
    assign q1_ready = ready_q[q1_idx] || q1_hit;
    assign q2_ready = ready_q[q2_idx] || q2_hit;
    assign q1_val   = q1_hit ? cdb_val : (ready_q[q1_idx] ? val_q[q1_idx] : 32'd0);
    assign q2_val   = q2_hit ? cdb_val : (ready_q[q2_idx] ? val_q[q2_idx] : 32'd0);

    assign dbg_head  = head_q;
    assign dbg_tail  = tail_q;
    assign dbg_count = count_q;

    always_comb begin
        busy_d    = busy_q;
        ready_d   = ready_q;
        is_br_d   = is_br_q;
        mispred_d = mispred_q;
        rd_d      = rd_q;
        val_d     = val_q;
        target_d  = target_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (rst) begin
            busy_d    = '0;
            ready_d   = '0;
            mispred_d = '0;
            is_br_d   = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
        end else if (jp_wrong) begin
            // Flush wipes everything younger than the branch, including this cycle's traffic.
            busy_d  = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cdb_valid && rdy && busy_q[cdb_idx]) begin
                ready_d[cdb_idx]   = 1'b1;
                val_d[cdb_idx]     = cdb_val;
                mispred_d[cdb_idx] = cdb_mispred;
                target_d[cdb_idx]  = cdb_target;
            end
            if (commit) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + 4'd1;
            end
            if (accept) begin
                busy_d[tail_q]    = 1'b1;
                ready_d[tail_q]   = 1'b0;
                mispred_d[tail_q] = 1'b0;
                is_br_d[tail_q]   = issue_is_br;
                rd_d[tail_q]      = issue_rd;
                tail_d            = tail_q + 4'd1;
            end
            count_d = count_q + {4'd0, accept} - {4'd0, commit};
        end
    end

    always_ff @(posedge clk) begin
        busy_q    <= busy_d;
        ready_q   <= ready_d;
        is_br_q   <= is_br_d;
        mispred_q <= mispred_d;
        rd_q      <= rd_d;
        val_q     <= val_d;
        target_q  <= target_d;
        head_q    <= head_d;
        tail_q    <= tail_d;
        count_q   <= count_d;
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: issue, out-of-order completion, full/wrap,
// mispredict flush, bypass, stall and mid-run reset.
module tb_reorder_buffer;

    logic        clk, rst, rdy;
    logic        issue_valid, issue_is_br;
    logic [4:0]  issue_rd;
    logic        rob_full, upd;
    logic [3:0]  upd_idx;
    logic [4:0]  upd_rd;
    logic        cdb_valid, cdb_mispred;
    logic [3:0]  cdb_idx;
    logic [31:0] cdb_val, cdb_target;
    logic [3:0]  q1_idx, q2_idx;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_val, q2_val;
    logic        write, jp_wrong;
    logic [3:0]  write_idx;
    logic [4:0]  write_rd;
    logic [31:0] new_val, redirect_pc;
    logic [3:0]  dbg_head, dbg_tail;
    logic [4:0]  dbg_count;

    int checks = 0;
    int failures = 0;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
        .rob_full(rob_full), .upd(upd), .upd_idx(upd_idx), .upd_rd(upd_rd),
        .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_val(cdb_val),
        .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
        .q1_idx(q1_idx), .q2_idx(q2_idx),
        .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_val(q1_val), .q2_val(q2_val),
        .write(write), .write_idx(write_idx), .write_rd(write_rd), .new_val(new_val),
        .jp_wrong(jp_wrong), .redirect_pc(redirect_pc),
        .dbg_head(dbg_head), .dbg_tail(dbg_tail), .dbg_count(dbg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        issue_is_br = 1'b0;
        cdb_valid   = 1'b0;
        cdb_idx     = 4'd0;
        cdb_val     = 32'd0;
        cdb_mispred = 1'b0;
        cdb_target  = 32'd0;
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic br);
        idle();
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_is_br = br;
        tick();
    endtask

    task automatic bcast(input logic [3:0] idx, input logic [31:0] val,
                         input logic mp, input logic [31:0] tgt);
        idle();
        cdb_valid   = 1'b1;
        cdb_idx     = idx;
        cdb_val     = val;
        cdb_mispred = mp;
        cdb_target  = tgt;
    endtask

    initial begin
        rdy = 1'b1;
        q1_idx = 4'd0;
        q2_idx = 4'd0;
        idle();
        // Reset holds off an in-flight issue.
        rst = 1'b1;
        issue_valid = 1'b1;
        issue_rd = 5'd3;
        #1;
        check("rst_upd", upd, 0);
        check("rst_full", rob_full, 0);
        check("rst_write", write, 0);
        check("rst_jp", jp_wrong, 0);
        tick();
        tick();
        check("rst_count", dbg_count, 0);
        check("rst_head", dbg_head, 0);
        check("rst_tail", dbg_tail, 0);

        // Single instruction.
        do_reset();
        idle();
        issue_valid = 1'b1;
        issue_rd = 5'd5;
        #1;
        check("s_upd", upd, 1);
        check("s_upd_idx", upd_idx, 0);
        check("s_upd_rd", upd_rd, 5);
        tick();
        bcast(4'd0, 32'h1234, 1'b0, 32'd0);
        #1;
        check("s_nowrite", write, 0);
        tick();
        idle();
        #1;
        check("s_write", write, 1);
        check("s_write_idx", write_idx, 0);
        check("s_write_rd", write_rd, 5);
        check("s_new_val", new_val, 32'h1234);
        check("s_jp", jp_wrong, 0);
        check("s_redirect", redirect_pc, 0);
        tick();
        check("s_count", dbg_count, 0);

        // Out-of-order completion, in-order commit.
        do_reset();
        issue(5'd1, 1'b0);
        issue(5'd2, 1'b0);
        issue(5'd3, 1'b0);
        bcast(4'd2, 32'h22, 1'b0, 32'd0);
        #1;
        check("o_w0", write, 0);
        tick();
        bcast(4'd0, 32'h20, 1'b0, 32'd0);
        #1;
        check("o_w1", write, 0);
        tick();
        bcast(4'd1, 32'h21, 1'b0, 32'd0);
        #1;
        check("o_c0", write, 1);
        check("o_c0_idx", write_idx, 0);
        check("o_c0_rd", write_rd, 1);
        check("o_c0_val", new_val, 32'h20);
        tick();
        idle();
        #1;
        check("o_c1", write, 1);
        check("o_c1_idx", write_idx, 1);
        check("o_c1_val", new_val, 32'h21);
        tick();
        #1;
        check("o_c2", write, 1);
        check("o_c2_idx", write_idx, 2);
        check("o_c2_rd", write_rd, 3);
        check("o_c2_val", new_val, 32'h22);
        tick();
        check("o_done", write, 0);
        check("o_count", dbg_count, 0);

        // Full and wrap.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            idle();
            issue_valid = 1'b1;
            issue_rd = 5'(i + 1);
            #1;
            check("f_upd_idx", upd_idx, i);
            tick();
        end
        issue_valid = 1'b1;
        #1;
        check("f_full", rob_full, 1);
        check("f_count", dbg_count, 16);
        check("f_ignored", upd, 0);
        tick();
        check("f_count_hold", dbg_count, 16);
        bcast(4'd0, 32'hA0, 1'b0, 32'd0);
        tick();
        idle();
        issue_valid = 1'b1;
        issue_rd = 5'd7;
        #1;
        check("f_commit", write, 1);
        check("f_full_during_commit", rob_full, 1);
        check("f_no_upd_during_commit", upd, 0);
        tick();
        #1;
        check("f_count15", dbg_count, 15);
        check("f_wrap_upd", upd, 1);
        check("f_wrap_idx", upd_idx, 0);
        tick();
        check("f_tail", dbg_tail, 1);
        check("f_head", dbg_head, 1);

        // Mispredicted branch at idx3 with younger entries 4..6.
        do_reset();
        for (int i = 0; i < 7; i++) issue(5'(i + 8), (i == 3));
        bcast(4'd0, 32'h40, 1'b0, 32'd0);
        tick();
        bcast(4'd1, 32'h41, 1'b1, 32'h999);
        tick();
        bcast(4'd2, 32'h42, 1'b0, 32'd0);
        #1;
        check("m_nonbr_mispred_jp", jp_wrong, 0);
        tick();
        bcast(4'd3, 32'h44, 1'b1, 32'h80);
        #1;
        check("m_pre_jp", jp_wrong, 0);
        check("m_pre_redirect", redirect_pc, 0);
        tick();
        bcast(4'd5, 32'h55, 1'b0, 32'd0);
        issue_valid = 1'b1;
        issue_rd = 5'd9;
        #1;
        check("m_write", write, 1);
        check("m_write_idx", write_idx, 3);
        check("m_write_rd", write_rd, 11);
        check("m_new_val", new_val, 32'h44);
        check("m_jp", jp_wrong, 1);
        check("m_redirect", redirect_pc, 32'h80);
        check("m_upd_blocked", upd, 0);
        tick();
        bcast(4'd5, 32'h55, 1'b0, 32'd0);
        q1_idx = 4'd5;
        #1;
        check("m_count", dbg_count, 0);
        check("m_full", rob_full, 0);
        check("m_q1_ready", q1_ready, 0);
        tick();
        idle();
        #1;
        check("m_ignored_write", write, 0);
        check("m_ignored_q1", q1_ready, 0);
        check("m_tail", dbg_tail, 0);

        // Bypass and stall.
        do_reset();
        issue(5'd1, 1'b0);
        issue(5'd2, 1'b0);
        issue(5'd3, 1'b0);
        bcast(4'd2, 32'd7, 1'b0, 32'd0);
        q1_idx = 4'd2;
        q2_idx = 4'd1;
        #1;
        check("b_q1_ready", q1_ready, 1);
        check("b_q1_val", q1_val, 7);
        check("b_q2_ready", q2_ready, 0);
        check("b_q2_val", q2_val, 0);
        tick();
        bcast(4'd0, 32'd9, 1'b0, 32'd0);
        #1;
        check("b_q1_stored", q1_val, 7);
        tick();
        idle();
        rdy = 1'b0;
        issue_valid = 1'b1;
        #1;
        check("st_write", write, 0);
        check("st_upd", upd, 0);
        check("st_q1_ready", q1_ready, 1);
        check("st_q1_val", q1_val, 7);
        tick();
        check("st_head", dbg_head, 0);
        check("st_tail", dbg_tail, 3);
        check("st_count", dbg_count, 3);
        idle();
        rdy = 1'b1;
        #1;
        check("st_resume", write, 1);
        check("st_resume_val", new_val, 9);
        tick();
        check("st_count_after", dbg_count, 2);

        // Reset mid-run with nine entries in flight.
        do_reset();
        for (int i = 0; i < 9; i++) issue(5'(i + 1), 1'b0);
        check("r_count9", dbg_count, 9);
        bcast(4'd0, 32'h5, 1'b0, 32'd0);
        tick();
        rst = 1'b1;
        issue_valid = 1'b1;
        #1;
        check("r_write_in_rst", write, 0);
        check("r_upd_in_rst", upd, 0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        check("r_count", dbg_count, 0);
        check("r_full", rob_full, 0);
        check("r_write", write, 0);
        check("r_upd_idx", upd_idx, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
